// File: rtl/half2_dump_if.sv
// Result handshake between the accumulate-and-dump stage and its consumer:
// a one-deep valid/ready register carrying the averaged a/b pair.
interface half2_dump_if #(
  parameter int ow = 16
);
  logic signed [ow-1:0] out_a;
  logic signed [ow-1:0] out_b;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_a,
    output out_b,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_a,
    input  out_b,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/half2_dump.sv
// Accumulate-and-dump averager for the interleaved a/b half-band output:
// re-pairs samples, averages 2^L pairs, rounds half up and saturates.
module half2_dump #(
  parameter int dw   = 17,
  parameter int ow   = 16,
  parameter int lmax = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [dw-1:0] d,
  input  logic                 ab,
  input  logic [2:0]           log2n,
  input  logic                 clear,
  half2_dump_if.master         res,
  output logic                 clip,
  output logic                 overrun,
  output logic                 align_err
);

  localparam int aw = dw + lmax;
  localparam int sw = aw + 1;
  localparam logic [lmax-1:0]        all_ones = '1;
  localparam logic signed [sw-1:0]   max_v    = sw'((1 << (ow - 1)) - 1);
  localparam logic signed [sw-1:0]   min_v    = ~max_v;

  logic signed [dw-1:0] a_hold_q, a_hold_d;
  logic                 a_ok_q, a_ok_d;
  logic                 first_q, first_d;
  logic [2:0]           l_q, l_d;
  logic [lmax-1:0]      cnt_q, cnt_d;
  logic signed [aw-1:0] acc_a_q, acc_a_d;
  logic signed [aw-1:0] acc_b_q, acc_b_d;
  logic signed [ow-1:0] out_a_q, out_a_d;
  logic signed [ow-1:0] out_b_q, out_b_d;
  logic                 out_valid_q, out_valid_d;
  logic                 clip_q, clip_d;
  logic                 overrun_q, overrun_d;
  logic                 align_err_q, align_err_d;

  logic [2:0]           l_req;
  logic [2:0]           l_cur;
  logic [lmax-1:0]      cnt_last;
  logic                 last;
  logic signed [aw-1:0] a_ext;
  logic signed [aw-1:0] b_ext;
  logic signed [sw-1:0] rnd;
  logic signed [sw-1:0] sum_a;
  logic signed [sw-1:0] sum_b;
  logic signed [sw-1:0] shf_a;
  logic signed [sw-1:0] shf_b;
  logic                 sat_a;
  logic                 sat_b;
  logic signed [ow-1:0] res_a;
  logic signed [ow-1:0] res_b;

  function automatic logic signed [ow-1:0] saturate(input logic signed [sw-1:0] v);
    if (v > max_v) begin
      return max_v[ow-1:0];
    end else if (v < min_v) begin
      return min_v[ow-1:0];
    end else begin
      return v[ow-1:0];
    end
  endfunction

  // Datapath: the frame length is taken live from log2n on a frame's first pair
  always_comb begin
    l_req    = (log2n > 3'(lmax)) ? 3'(lmax) : log2n;
    l_cur    = (cnt_q == '0) ? l_req : l_q;
    cnt_last = ~(all_ones << l_cur);
    last     = (cnt_q == cnt_last);
    a_ext    = {{lmax{a_hold_q[dw-1]}}, a_hold_q};
    b_ext    = {{lmax{d[dw-1]}}, d};
    rnd      = (sw'(1) << l_cur) >> 1;
    sum_a    = {acc_a_q[aw-1], acc_a_q} + {a_ext[aw-1], a_ext} + rnd;
    sum_b    = {acc_b_q[aw-1], acc_b_q} + {b_ext[aw-1], b_ext} + rnd;
    shf_a    = sum_a >>> l_cur;
    shf_b    = sum_b >>> l_cur;
    sat_a    = (shf_a > max_v) || (shf_a < min_v);
    sat_b    = (shf_b > max_v) || (shf_b < min_v);
    res_a    = saturate(shf_a);
    res_b    = saturate(shf_b);
  end

  always_comb begin
    a_hold_d    = a_hold_q;
    a_ok_d      = a_ok_q;
    first_d     = 1'b0;
    l_d         = l_q;
    cnt_d       = cnt_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    clip_d      = clear ? 1'b0 : clip_q;
    overrun_d   = clear ? 1'b0 : overrun_q;
    align_err_d = clear ? 1'b0 : align_err_q;

    if (out_valid_q && res.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (!ab) begin
      a_hold_d = d;
      a_ok_d   = 1'b1;
      if (a_ok_q) begin
        align_err_d = 1'b1;
      end
    end else if (a_ok_q) begin
      a_ok_d = 1'b0;
      l_d    = l_cur;
      if (last) begin
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
        if (sat_a || sat_b) begin
          clip_d = 1'b1;
        end
        if (!out_valid_q || res.out_ready) begin
          out_a_d     = res_a;
          out_b_d     = res_b;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        acc_a_d = acc_a_q + a_ext;
        acc_b_d = acc_b_q + b_ext;
        cnt_d   = cnt_q + lmax'(1);
      end
    end else if (!first_q) begin
      align_err_d = 1'b1;
    end
  end

  // first_q marks the single cycle after reset where a stray b sample is silent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hold_q    <= '0;
      a_ok_q      <= 1'b0;
      first_q     <= 1'b1;
      l_q         <= '0;
      cnt_q       <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      a_hold_q    <= a_hold_d;
      a_ok_q      <= a_ok_d;
      first_q     <= first_d;
      l_q         <= l_d;
      cnt_q       <= cnt_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
      align_err_q <= align_err_d;
    end
  end

  assign res.out_a     = out_a_q;
  assign res.out_b     = out_b_q;
  assign res.out_valid = out_valid_q;
  assign clip          = clip_q;
  assign overrun       = overrun_q;
  assign align_err     = align_err_q;

endmodule
